// File: rtl/game_tick_scheduler_if.sv
// Bundle of frame-control and phase-handshake signals between the game
// tick scheduler and the rest of the game (tick source, top FSM, subsystems).
// With GAME_SCHED_WATCHDOG_EN defined, the phase-timeout status is included.
interface game_tick_scheduler_if #(
    parameter int NUM_PHASES = 4,
    parameter int FRAME_W    = 16
);
    logic                  TICK_EARLY;
    logic                  TICK;
    logic                  PAUSE;
    logic                  STEP;
    logic [1:0]            SPEED;
    logic                  CLR_STATUS;
    logic [NUM_PHASES-1:0] PHASE_DONE;
    logic [NUM_PHASES-1:0] PHASE_START;
    logic                  BUSY;
    logic                  FRAME_COMMIT;
    logic [FRAME_W-1:0]    FRAME_COUNT;
    logic                  OVERRUN;
    logic [7:0]            OVERRUN_COUNT;
`ifdef GAME_SCHED_WATCHDOG_EN
    logic                  TIMEOUT_FLAG;
    logic [2:0]            TIMEOUT_PHASE;

    modport master (
        input  TICK_EARLY, TICK, PAUSE, STEP, SPEED, CLR_STATUS, PHASE_DONE,
        output PHASE_START, BUSY, FRAME_COMMIT, FRAME_COUNT, OVERRUN,
               OVERRUN_COUNT, TIMEOUT_FLAG, TIMEOUT_PHASE
    );

    modport slave (
        output TICK_EARLY, TICK, PAUSE, STEP, SPEED, CLR_STATUS, PHASE_DONE,
        input  PHASE_START, BUSY, FRAME_COMMIT, FRAME_COUNT, OVERRUN,
               OVERRUN_COUNT, TIMEOUT_FLAG, TIMEOUT_PHASE
    );
`else
    modport master (
        input  TICK_EARLY, TICK, PAUSE, STEP, SPEED, CLR_STATUS, PHASE_DONE,
        output PHASE_START, BUSY, FRAME_COMMIT, FRAME_COUNT, OVERRUN,
               OVERRUN_COUNT
    );

    modport slave (
        output TICK_EARLY, TICK, PAUSE, STEP, SPEED, CLR_STATUS, PHASE_DONE,
        input  PHASE_START, BUSY, FRAME_COMMIT, FRAME_COUNT, OVERRUN,
               OVERRUN_COUNT
    );
`endif
endinterface

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: launches one frame per accepted TICK_EARLY, walks the
// subsystem phases in order with a start/done handshake and commits the frame
// on TICK (or immediately after the last phase if TICK already came = overrun).
// Optional phase watchdog: define GAME_SCHED_WATCHDOG_EN to add PHASE_TIMEOUT,
// TIMEOUT_FLAG and TIMEOUT_PHASE.
module game_tick_scheduler #(
    parameter int NUM_PHASES    = 4,
    parameter int FRAME_W       = 16
`ifdef GAME_SCHED_WATCHDOG_EN
    ,
    parameter int PHASE_TIMEOUT = 4096
`endif
) (
    input  logic                  CLOCK_50,
    input  logic                  RESETN,
    game_tick_scheduler_if.master bus
);

    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [NUM_PHASES-1:0] START_ONE = NUM_PHASES'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_TICK = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic               start_pend_q, start_pend_d;
    logic [1:0]         div_cnt_q, div_cnt_d;
    logic               step_armed_q, step_armed_d;
    logic               pause_q, pause_d;
    logic               ovr_frame_q, ovr_frame_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         ovr_cnt_q, ovr_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic               phase_done;
    logic               phase_advance;
    logic               last_phase;
    logic               launch;
    logic               ovr_event;

`ifdef GAME_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(PHASE_TIMEOUT + 1);

    logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
    logic [WDW-1:0]     wd_elapsed;
    logic               to_flag_q, to_flag_d;
    logic [2:0]         to_phase_q, to_phase_d;
    logic               phase_timeout;

    // Cycles spent in the current phase (start cycle counts as 0) and the timeout decision.
    always_comb begin
        wd_elapsed    = start_pend_q ? '0 : wd_cnt_q;
        phase_timeout = (state_q == RUN) && !bus.PHASE_DONE[phase_q] &&
                        (wd_elapsed == WDW'(PHASE_TIMEOUT - 1));
    end
`endif

    // Next-state, phase sequencing, division/step bookkeeping and status updates.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        start_pend_d  = 1'b0;
        div_cnt_d     = div_cnt_q;
        step_armed_d  = step_armed_q;
        pause_d       = bus.PAUSE;
        ovr_frame_d   = ovr_frame_q;
        overrun_d     = overrun_q;
        ovr_cnt_d     = ovr_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        launch        = 1'b0;
        ovr_event     = 1'b0;
        phase_done    = bus.PHASE_DONE[phase_q];
        last_phase    = (phase_q == PW'(NUM_PHASES - 1));
`ifdef GAME_SCHED_WATCHDOG_EN
        phase_advance = phase_done | phase_timeout;
`else
        phase_advance = phase_done;
`endif

        if (pause_q && !bus.PAUSE) begin
            step_armed_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.TICK_EARLY) begin
                    if (!bus.PAUSE) begin
                        if (div_cnt_q == 2'd0) begin
                            launch    = 1'b1;
                            div_cnt_d = bus.SPEED;
                        end else begin
                            div_cnt_d = div_cnt_q - 2'd1;
                        end
                    end else if (step_armed_q) begin
                        launch = 1'b1;
                    end
                end
                if (launch) begin
                    state_d      = RUN;
                    phase_d      = '0;
                    start_pend_d = 1'b1;
                    ovr_frame_d  = 1'b0;
                    step_armed_d = 1'b0;
                end
            end
            RUN: begin
                if (phase_advance) begin
                    if (!last_phase) begin
                        phase_d      = phase_q + PW'(1);
                        start_pend_d = 1'b1;
                    end else if (ovr_frame_q || bus.TICK) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = WAIT_TICK;
                    end
                end
                if (bus.TICK && !(phase_advance && last_phase)) begin
                    ovr_event   = 1'b1;
                    ovr_frame_d = 1'b1;
                end
            end
            WAIT_TICK: begin
                if (bus.TICK) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == COMMIT) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end

        if (bus.STEP) begin
            step_armed_d = 1'b1;
        end

        if (ovr_event) begin
            overrun_d = 1'b1;
            if (bus.CLR_STATUS) begin
                ovr_cnt_d = 8'd1;
            end else if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end else if (bus.CLR_STATUS) begin
            overrun_d = 1'b0;
            ovr_cnt_d = 8'd0;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            start_pend_q <= 1'b0;
            div_cnt_q    <= 2'd0;
            step_armed_q <= 1'b0;
            pause_q      <= 1'b0;
            ovr_frame_q  <= 1'b0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= 8'd0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            start_pend_q <= start_pend_d;
            div_cnt_q    <= div_cnt_d;
            step_armed_q <= step_armed_d;
            pause_q      <= pause_d;
            ovr_frame_q  <= ovr_frame_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef GAME_SCHED_WATCHDOG_EN
    // Phase timer runs only in RUN; a timeout latches the stuck phase until cleared.
    always_comb begin
        wd_cnt_d   = '0;
        to_flag_d  = to_flag_q;
        to_phase_d = to_phase_q;
        if (state_q == RUN) begin
            wd_cnt_d = wd_elapsed + WDW'(1);
        end
        if (phase_timeout) begin
            to_flag_d  = 1'b1;
            to_phase_d = 3'(phase_q);
        end else if (bus.CLR_STATUS) begin
            to_flag_d  = 1'b0;
            to_phase_d = 3'd0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            wd_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
            to_phase_q <= 3'd0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            to_flag_q  <= to_flag_d;
            to_phase_q <= to_phase_d;
        end
    end

    assign bus.TIMEOUT_FLAG  = to_flag_q;
    assign bus.TIMEOUT_PHASE = to_phase_q;
`endif

    assign bus.PHASE_START   = (state_q == RUN && start_pend_q) ? (START_ONE << phase_q) : '0;
    assign bus.BUSY          = (state_q != IDLE);
    assign bus.FRAME_COMMIT  = (state_q == COMMIT);
    assign bus.FRAME_COUNT   = frame_cnt_q;
    assign bus.OVERRUN       = overrun_q;
    assign bus.OVERRUN_COUNT = ovr_cnt_q;

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Sequences one game frame per game-clock period across NUM_PHASES subsystems, e.g. input sample, physics, collision, render.
- Consumes the early/on-time tick pulses produced by the game clock generator.
- Launches phases in order with a start/done handshake, then commits the frame on the on-time tick.
- Provides pause, single-step, speed division and overrun accounting for the top-level game FSM.

Parameters:
NUM_PHASES, 4, number of sequenced subsystem phases (2..8)
FRAME_W, 16, width of frame counter

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESETN  in  1  reset, asynchronous, active-low
TICK_EARLY  in  1  one-cycle pulse, frame-prepare tick
TICK  in  1  one-cycle pulse, frame-commit tick
PAUSE  in  1  level; suppresses new frames
STEP  in  1  one-cycle pulse; arms exactly one frame while paused
SPEED  in  2  run one frame every SPEED+1 accepted TICK_EARLY pulses
CLR_STATUS  in  1  pulse; clears overrun status
PHASE_DONE  in  NUM_PHASES  per-phase completion pulse/level
PHASE_START  out  NUM_PHASES  one-hot, one-cycle start pulse
BUSY  out  1  high when state != IDLE
FRAME_COMMIT  out  1  one-cycle pulse, frame finished and committed
FRAME_COUNT  out  FRAME_W  committed frames, wraps
OVERRUN  out  1  sticky; a TICK arrived before all phases finished
OVERRUN_COUNT  out  8  saturating overrun count

Behaviour:
- Reset (RESETN low, async): state=IDLE, all outputs 0, div_cnt=0, step_armed=0, phase index=0.
- Fixed: one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, WAIT_TICK, COMMIT.
- IDLE, TICK_EARLY, PAUSE=0:
  - div_cnt==0 -> launch frame, div_cnt<=SPEED.
  - otherwise div_cnt<=div_cnt-1, no launch.
- IDLE, TICK_EARLY, PAUSE=1:
  - div_cnt held.
  - step_armed=1 -> launch and clear step_armed; otherwise nothing.
- STEP sets step_armed in any state and any PAUSE value.
- step_armed clears on launch or on PAUSE deassert.
- Launch: TICK_EARLY in cycle n -> state RUN, PHASE_START[0]=1 in cycle n+1.
- RUN, phase p:
  - PHASE_START[p] is high for exactly one cycle.
  - PHASE_DONE[p] is accepted from that same cycle onward, so combinational done is legal.
  - PHASE_DONE bits for j != p are ignored.
  - On DONE[p] with p<NUM_PHASES-1: PHASE_START[p+1] in the next cycle.
  - On DONE[last]: go to WAIT_TICK, or to COMMIT if an overrun was flagged this frame.
- WAIT_TICK: on TICK go to COMMIT.
- COMMIT (one cycle): FRAME_COMMIT=1, FRAME_COUNT+1 (wraps at 2^FRAME_W), then IDLE.
  - On-time latency: TICK in cycle m -> FRAME_COMMIT in cycle m+1.
- TICK in RUN (overrun):
  - OVERRUN<=1, OVERRUN_COUNT+1, saturating at 255; frame overrun flag set.
  - Phases continue; FRAME_COMMIT comes the cycle after DONE[last], with no wait for another TICK.
- TICK in the same cycle as DONE[last]: on time, no overrun, FRAME_COMMIT next cycle.
- TICK_EARLY while not IDLE: dropped; div_cnt and step_armed unaffected.
- TICK in IDLE: ignored.
- PAUSE asserted mid-frame: the current frame runs to commit; pause takes effect at the next TICK_EARLY.
- SPEED is sampled only at a reload; changes take effect after the current division period.
- CLR_STATUS clears OVERRUN and OVERRUN_COUNT. If an overrun occurs in the same cycle, the overrun wins: OVERRUN=1, count=1.

Optional Feature:
- Macro GAME_SCHED_WATCHDOG_EN.
- Defined:
  - Parameter PHASE_TIMEOUT, default 4096 cycles, is added.
  - Counter starts at PHASE_START[p].
  - If DONE[p] is not seen within PHASE_TIMEOUT cycles (inclusive of the start cycle): abort the phase, set sticky output TIMEOUT_FLAG, latch the phase index on output TIMEOUT_PHASE [2:0], and advance as if DONE[p] had arrived.
  - CLR_STATUS also clears TIMEOUT_FLAG and TIMEOUT_PHASE.
- Undefined: no extra ports or counters; RUN waits indefinitely for DONE.

Test Plan:
- Nominal, SPEED=0, NUM_PHASES=4, each DONE 3 cycles after its START; TICK_EARLY at cycle 10, TICK at cycle 265 -> START[0] at 11, START[1..3] spaced 4 cycles apart; FRAME_COMMIT at 266; FRAME_COUNT=1; OVERRUN=0.
- SPEED=2, 9 TICK_EARLY/TICK pairs with phases completing in time -> 3 frames launched (1st, 4th, 7th early ticks); FRAME_COUNT=3.
- Phase 2 holds DONE past TICK -> OVERRUN=1, OVERRUN_COUNT=1; FRAME_COMMIT the cycle after DONE[3]; next TICK_EARLY while still RUN is dropped. Then CLR_STATUS -> both cleared.
- PAUSE=1, 5 tick pairs -> no PHASE_START. STEP pulse -> exactly one frame on the next TICK_EARLY; FRAME_COUNT+1; the following early tick does not launch.
- RESETN low during RUN phase 1 -> all outputs 0 immediately; after release, the next TICK_EARLY restarts at START[0] with FRAME_COUNT=0.
- Watchdog build, PHASE_TIMEOUT=16, phase 1 never done -> TIMEOUT_FLAG=1, TIMEOUT_PHASE=1, START[2] 16 cycles after START[1], frame commits normally.
